// File: rtl/t2mi_ts_null_inserter.sv
// t2mi_ts_null_inserter: buffers bursty T2-MI TS packets and emits a constant-rate TS, filling empty slots with null packets.
// Optional NULL_COUNT_EN macro adds the NULL_CNT saturating null-packet counter output.
module t2mi_ts_null_inserter #(
    parameter int          PKT_LEN   = 188,
    parameter int          FIFO_PKTS = 2,
    parameter logic [12:0] NULL_PID  = 13'h1FFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA_IN,
    input  logic       DVALID_IN,
    input  logic       PSYNC_IN,
    input  logic       OUT_EN,
    output logic [7:0] DATA_OUT,
    output logic       DVALID_OUT,
    output logic       PSYNC_OUT,
    output logic       OVF
`ifdef NULL_COUNT_EN
    ,
    output logic [15:0] NULL_CNT
`endif
);
    localparam int DEPTH = FIFO_PKTS * PKT_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(PKT_LEN);
    localparam int PW    = $clog2(FIFO_PKTS + 1);

    typedef enum logic [1:0] {IN_IDLE, IN_WRITE, IN_DROP} in_state_t;
    typedef enum logic [1:0] {OUT_SEL, OUT_FIFO, OUT_NULL} out_state_t;

    // RAM size is not a power of two, so wrap by compare
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [7:0]    r_mem [DEPTH];
    in_state_t     r_in_state, w_in_nxt;
    out_state_t    r_out_state, w_out_nxt;
    logic [CW-1:0] r_in_cnt, w_in_cnt_nxt, r_out_cnt, w_out_cnt_nxt;
    logic [AW-1:0] r_wr_ptr, r_base, r_rd_ptr, w_wa;
    logic [OW-1:0] r_used, w_used_eff;
    logic [PW-1:0] r_pkts;
    logic          w_rewind, w_fit, w_we, w_commit, w_drop, w_take, w_rd;
    logic [7:0]    w_null_byte;

    // r_used counts committed unread bytes plus bytes of the packet being written
    assign w_rewind   = DVALID_IN & PSYNC_IN & (r_in_state == IN_WRITE);
    assign w_used_eff = r_used - (w_rewind ? OW'(r_in_cnt) : '0);
    assign w_fit      = (OW'(DEPTH) - w_used_eff) >= OW'(PKT_LEN);
    assign w_wa       = w_rewind ? r_base : r_wr_ptr;

    always_comb begin
        w_in_nxt     = r_in_state;
        w_in_cnt_nxt = r_in_cnt;
        w_we         = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        if (DVALID_IN) begin
            if (PSYNC_IN) begin
                w_in_cnt_nxt = CW'(1);
                w_we         = w_fit;
                w_drop       = ~w_fit;
                w_in_nxt     = w_fit ? IN_WRITE : IN_DROP;
            end else if (r_in_state != IN_IDLE) begin
                w_we         = (r_in_state == IN_WRITE);
                w_in_cnt_nxt = r_in_cnt + 1'b1;
                if (r_in_cnt == CW'(PKT_LEN - 1)) begin
                    w_commit     = w_we;
                    w_in_nxt     = IN_IDLE;
                    w_in_cnt_nxt = '0;
                end
            end
        end
    end

    // Source is chosen only at packet boundaries; same-cycle commits are not yet counted
    assign w_take = OUT_EN & (r_out_state == OUT_SEL) & (r_pkts != '0);
    assign w_rd   = OUT_EN & (w_take | (r_out_state == OUT_FIFO));

    always_comb begin
        w_out_nxt     = r_out_state;
        w_out_cnt_nxt = r_out_cnt;
        if (OUT_EN) begin
            if (r_out_state == OUT_SEL) begin
                w_out_nxt     = w_take ? OUT_FIFO : OUT_NULL;
                w_out_cnt_nxt = CW'(1);
            end else if (r_out_cnt == CW'(PKT_LEN - 1)) begin
                w_out_nxt     = OUT_SEL;
                w_out_cnt_nxt = '0;
            end else begin
                w_out_cnt_nxt = r_out_cnt + 1'b1;
            end
        end
    end

    assign w_null_byte = (r_out_cnt == CW'(0)) ? 8'h47 :
                         (r_out_cnt == CW'(1)) ? {3'b000, NULL_PID[12:8]} :
                         (r_out_cnt == CW'(2)) ? NULL_PID[7:0] :
                         (r_out_cnt == CW'(3)) ? 8'h10 : 8'hFF;

    always_ff @(posedge CLK) begin
        if (w_we) r_mem[w_wa] <= DATA_IN;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_SEL;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_base      <= '0;
            r_rd_ptr    <= '0;
            r_used      <= '0;
            r_pkts      <= '0;
            DATA_OUT    <= '0;
            DVALID_OUT  <= 1'b0;
            PSYNC_OUT   <= 1'b0;
            OVF         <= 1'b0;
        end else begin
            r_in_state  <= w_in_nxt;
            r_out_state <= w_out_nxt;
            r_in_cnt    <= w_in_cnt_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_wr_ptr    <= w_we ? inc(w_wa) : w_wa;
            r_base      <= w_commit ? inc(w_wa) : r_base;
            r_rd_ptr    <= w_rd ? inc(r_rd_ptr) : r_rd_ptr;
            r_used      <= w_used_eff + OW'(w_we) - OW'(w_rd);
            r_pkts      <= r_pkts + PW'(w_commit) - PW'(w_take);
            if (OUT_EN) DATA_OUT <= w_rd ? r_mem[r_rd_ptr] : w_null_byte;
            DVALID_OUT  <= OUT_EN;
            PSYNC_OUT   <= OUT_EN & (r_out_state == OUT_SEL);
            OVF         <= w_drop;
        end
    end

`ifdef NULL_COUNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) NULL_CNT <= '0;
        else if (OUT_EN && r_out_state == OUT_SEL && !w_take && NULL_CNT != 16'hFFFF) NULL_CNT <= NULL_CNT + 1'b1;
    end
`endif
endmodule

// File: doc/t2mi_ts_null_inserter.md
Name: t2mi_ts_null_inserter

Overview:
- Downstream of the T2-MI packer. Consumes its bursty 188-byte T2-MI TS packets (data/dvalid/psync).
- Emits a constant-rate TS at externally paced byte slots (OUT_EN). Fills every packet slot with no complete buffered packet with a null packet (PID 0x1FFF).
- Drives the board TS output pins. Single clock domain (DCLK).

Parameters:
- PKT_LEN, 188: TS packet length in bytes.
- FIFO_PKTS, 2: buffer depth in whole packets; RAM = FIFO_PKTS*PKT_LEN bytes.
- NULL_PID, 13'h1FFF: PID written into inserted packets.

Ports:
- CLK  in  1  byte clock (DCLK).
- RST  in  1  asynchronous, active-low reset.
- DATA_IN  in  8  T2-MI TS byte from packer.
- DVALID_IN  in  1  DATA_IN valid this cycle.
- PSYNC_IN  in  1  high with byte 0 (0x47) of a packet; qualified by DVALID_IN.
- OUT_EN  in  1  output byte slot strobe; at most one byte per strobe.
- DATA_OUT  out  8  output TS byte.
- DVALID_OUT  out  1  DATA_OUT valid.
- PSYNC_OUT  out  1  high with byte 0 of each output packet.
- OVF  out  1  one-cycle pulse when an input packet is dropped for lack of space.

Behaviour:
- Reset (RST=0, async):
  - DATA_OUT=0, DVALID_OUT=0, PSYNC_OUT=0, OVF=0.
  - Pointers, counters and committed-packet count = 0.
  - Both FSMs go to idle. Content of a packet in progress is discarded.
- Input FSM, one byte per cycle when DVALID_IN=1:
  - IN_IDLE: ignore bytes until PSYNC_IN. At PSYNC, if free space >= PKT_LEN, go to IN_WRITE and write byte 0. Otherwise pulse OVF and go to IN_DROP.
  - IN_WRITE: write bytes, in_cnt 0..PKT_LEN-1. At byte PKT_LEN-1, commit: pkt_count+1, new packet base = wr_ptr, return to IN_IDLE.
  - IN_DROP: discard until PKT_LEN bytes counted, then IN_IDLE.
  - PSYNC_IN in IN_WRITE/IN_DROP with in_cnt != 0 (short packet): rewind wr_ptr to the packet base, no commit, then handle as a fresh PSYNC in the same cycle.
  - A DVALID_IN gap does not abort a packet.
- Free space = RAM size − (committed bytes not yet read + bytes of the packet being written). Occupancy is counted in bytes, width ceil(log2(FIFO_PKTS*PKT_LEN+1)).
- Pointer wrap: wr_ptr and rd_ptr wrap from FIFO_PKTS*PKT_LEN−1 to 0. The RAM size is not a power of two, so wrap is by explicit compare.
- Output FSM, advances only on OUT_EN:
  - OUT_SEL: at an OUT_EN with out_cnt=0, if pkt_count>0, decrement pkt_count and go to OUT_FIFO. Else go to OUT_NULL. The byte 0 of the chosen source is emitted on this same strobe.
  - OUT_FIFO/OUT_NULL: out_cnt increments per OUT_EN. After byte PKT_LEN−1, out_cnt=0 and state returns to OUT_SEL.
  - The source decision is made only at packet boundaries. A packet completing mid-null-packet waits for the next boundary.
- Null packet bytes:
  - byte 0 = 0x47.
  - byte 1 = {3'b000, NULL_PID[12:8]} (0x1F).
  - byte 2 = NULL_PID[7:0] (0xFF).
  - byte 3 = 0x10 (payload only, CC=0).
  - bytes 4..187 = 0xFF.
- Latency: DATA_OUT/DVALID_OUT/PSYNC_OUT are registered and valid exactly 1 cycle after OUT_EN. RAM read is synchronous, with the address presented on the OUT_EN cycle.
  - DVALID_OUT=1 only in the cycle after each OUT_EN; 0 otherwise. DATA_OUT holds its last value.
  - PSYNC_OUT=1 with byte 0 only.
- Simultaneous events:
  - Commit and OUT_SEL read-start in the same cycle: pkt_count is unchanged net. A packet committing in that cycle is not eligible for that boundary.
  - Write and read in the same cycle: both proceed. Occupancy is updated by +1−1.
- No back-pressure on input. Overflow is resolved by whole-packet drop only; a packet is never partially emitted.

Optional Feature:
- Macro NULL_COUNT_EN.
- When defined, adds output NULL_CNT [15:0]: the count of null packets inserted, incremented at each OUT_SEL→OUT_NULL decision. It saturates at 16'hFFFF and resets to 0.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, OUT_EN every 4th cycle, no input → continuous null packets with bytes 47 1F FF 10 FF…FF. PSYNC_OUT every 188 output bytes. NULL_CNT increments per packet.
- One 188-byte packet (47 10 00 1x…) input while output is mid-null → the null packet completes, then the packet is emitted byte-exact at the next boundary, followed by nulls.
- Three back-to-back packets with no OUT_EN (FIFO_PKTS=2) → OVF pulses once at the third PSYNC. Later output shows exactly packets 1 and 2.
- PSYNC_IN at in_cnt=100 → the 100-byte fragment is never output. The following 188-byte packet is output intact.
- Commit on the same cycle as an OUT_EN boundary with the FIFO otherwise empty → a null packet is emitted, then the packet at the next boundary.
- RST low mid-output (out_cnt=50) → outputs 0 immediately. After release, the first output byte is 0x47 with PSYNC_OUT=1 and the buffer is empty.
